// File: rtl/line_burst_responder_pkg.sv
// Shared types and sizing for the line-to-burst responder.
// A cache line moves to and from memory as N_BEATS beats of S_BURST bits each.
package line_burst_responder_pkg;

  localparam int unsigned S_LINE  = 256;
  localparam int unsigned S_BURST = 64;
  localparam int unsigned N_BEATS = S_LINE / S_BURST;
  localparam int unsigned S_OFF   = $clog2(S_LINE / 8);
  localparam int unsigned BEAT_W  = $clog2(N_BEATS);

  typedef logic [BEAT_W-1:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(N_BEATS - 1);

  // Low address bits that select a byte inside a line.
  localparam logic [31:0] OFF_MASK = 32'((64'd1 << S_OFF) - 64'd1);

  typedef enum logic [1:0] {
    StIdle,
    StRdBurst,
    StWrBurst,
    StDone
  } burst_state_t;

  // Line-aligned base address for the memory burst.
  function automatic logic [31:0] line_base(logic [31:0] addr);
    return addr & ~OFF_MASK;
  endfunction

endpackage

// File: rtl/line_burst_responder_buf.sv
// Line register used as the staging buffer for one burst.
// Loads a whole line at once, or writes and reads one beat-sized slice by index.
module line_burst_responder_buf
  import line_burst_responder_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [S_LINE-1:0]  load_data_i,
  input  logic               wr_en_i,
  input  beat_idx_t          wr_idx_i,
  input  logic [S_BURST-1:0] wr_data_i,
  input  beat_idx_t          rd_idx_i,
  output logic [S_BURST-1:0] rd_data_o,
  output logic [S_LINE-1:0]  line_o
);

  logic [N_BEATS-1:0][S_BURST-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (load_i) begin
      line_d = load_data_i;
    end else if (wr_en_i) begin
      line_d[wr_idx_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign rd_data_o = line_q[rd_idx_i];
  assign line_o    = line_q;

endmodule

// File: rtl/line_burst_responder.sv
// Turns one 256-bit cache line read/write into a 4-beat memory burst and
// returns the assembled line (read) or a completion (write) with a 1-cycle pulse.
module line_burst_responder
  import line_burst_responder_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               line_read_i,
  input  logic               line_write_i,
  input  logic [31:0]        line_address_i,
  input  logic [S_LINE-1:0]  line_wdata_i,
  output logic [S_LINE-1:0]  line_rdata_o,
  output logic               line_resp_o,
  output logic [31:0]        burst_address_o,
  output logic               burst_read_o,
  output logic               burst_write_o,
  output logic [S_BURST-1:0] burst_wdata_o,
  input  logic [S_BURST-1:0] burst_rdata_i,
  input  logic               burst_resp_i
);

  burst_state_t       state_q, state_d;
  beat_idx_t          beat_q, beat_d;
  logic [31:0]        addr_q, addr_d;
  logic               buf_load;
  logic               buf_wr_en;
  logic [S_BURST-1:0] buf_rd_data;
  logic [S_LINE-1:0]  buf_line;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    buf_load  = 1'b0;
    buf_wr_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A simultaneous read is dropped; the write takes priority.
        if (line_write_i) begin
          state_d  = StWrBurst;
          addr_d   = line_address_i;
          buf_load = 1'b1;
        end else if (line_read_i) begin
          state_d = StRdBurst;
          addr_d  = line_address_i;
        end
      end
      StRdBurst: begin
        if (burst_resp_i) begin
          buf_wr_en = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = StDone;
          end else begin
            beat_d = beat_q + beat_idx_t'(1);
          end
        end
      end
      StWrBurst: begin
        if (burst_resp_i) begin
          if (beat_q == LAST_BEAT) begin
            state_d = StDone;
          end else begin
            beat_d = beat_q + beat_idx_t'(1);
          end
        end
      end
      StDone: begin
        beat_d  = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      beat_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
    end
  end

  line_burst_responder_buf u_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (buf_load),
    .load_data_i (line_wdata_i),
    .wr_en_i     (buf_wr_en),
    .wr_idx_i    (beat_q),
    .wr_data_i   (burst_rdata_i),
    .rd_idx_i    (beat_q),
    .rd_data_o   (buf_rd_data),
    .line_o      (buf_line)
  );

  // All outputs decode registered state only; no line_* input reaches burst_* directly.
  assign burst_read_o    = (state_q == StRdBurst);
  assign burst_write_o   = (state_q == StWrBurst);
  assign line_resp_o     = (state_q == StDone);
  assign burst_address_o = line_base(addr_q);
  assign burst_wdata_o   = burst_write_o ? buf_rd_data : '0;
  assign line_rdata_o    = line_resp_o ? buf_line : '0;

endmodule
